// File: rtl/key_debouncer.sv
// Key debouncer: synchronises active-low raw keys and filters contact bounce
// with an independent counter FSM per key. Emits a debounced level plus
// single-cycle press/release pulses.
module key_debouncer #(
  parameter int unsigned W               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] key,
  output logic [W-1:0] down,
  output logic [W-1:0] pressed,
  output logic [W-1:0] released
);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  // Last count value of a wait state; reaching it ends the wait before overflow.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     r_sync1;
  logic [W-1:0]     r_sync2;
  logic [W-1:0]     w_key_s;
  state_e           r_state   [W];
  state_e           w_state_d [W];
  logic [CNT_W-1:0] r_cnt     [W];
  logic [CNT_W-1:0] w_cnt_d   [W];
  logic [W-1:0]     r_down;
  logic [W-1:0]     r_pressed;
  logic [W-1:0]     r_released;
  logic [W-1:0]     w_down_d;
  logic [W-1:0]     w_pressed_d;
  logic [W-1:0]     w_released_d;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  // Active-high synchronised key level.
  assign w_key_s = ~r_sync2;

  // Per-key FSM next state, counter and registered-output next values.
  always_comb begin
    w_pressed_d  = '0;
    w_released_d = '0;
    w_down_d     = '0;
    for (int i = 0; i < W; i++) begin
      w_state_d[i] = r_state[i];
      w_cnt_d[i]   = r_cnt[i];
      unique case (r_state[i])
        StReleased: begin
          if (w_key_s[i]) begin
            w_state_d[i] = StPressWait;
            w_cnt_d[i]   = '0;
          end
        end
        StPressWait: begin
          if (!w_key_s[i]) begin
            w_state_d[i] = StReleased;
          end else if (r_cnt[i] == CntLast) begin
            w_state_d[i]   = StPressed;
            w_pressed_d[i] = 1'b1;
          end else begin
            w_cnt_d[i] = r_cnt[i] + 1'b1;
          end
        end
        StPressed: begin
          if (!w_key_s[i]) begin
            w_state_d[i] = StReleaseWait;
            w_cnt_d[i]   = '0;
          end
        end
        StReleaseWait: begin
          if (w_key_s[i]) begin
            w_state_d[i] = StPressed;
          end else if (r_cnt[i] == CntLast) begin
            w_state_d[i]    = StReleased;
            w_released_d[i] = 1'b1;
          end else begin
            w_cnt_d[i] = r_cnt[i] + 1'b1;
          end
        end
        default: w_state_d[i] = StReleased;
      endcase
      w_down_d[i] = (w_state_d[i] == StPressed) || (w_state_d[i] == StReleaseWait);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < W; i++) begin
        r_state[i] <= StReleased;
        r_cnt[i]   <= '0;
      end
      r_down     <= '0;
      r_pressed  <= '0;
      r_released <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        r_state[i] <= w_state_d[i];
        r_cnt[i]   <= w_cnt_d[i];
      end
      r_down     <= w_down_d;
      r_pressed  <= w_pressed_d;
      r_released <= w_released_d;
    end
  end

  assign down     = r_down;
  assign pressed  = r_pressed;
  assign released = r_released;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: a window-based reference model pushes the
// expected outputs every clock; a negedge monitor pops and compares.
module tb_key_debouncer;

  localparam int unsigned W  = 4;
  localparam int unsigned DC = 4;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] key;
  logic [W-1:0] down;
  logic [W-1:0] pressed;
  logic [W-1:0] released;

  int n_checks;
  int n_errors;
  int int_cnt;

  key_debouncer #(
    .W              (W),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key     (key),
    .down    (down),
    .pressed (pressed),
    .released(released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got down/pressed/released=%b required %b", name, $time, act, exp);
    end
  endtask

  // Reference model: raw key levels captured per edge; the FSM sees the value
  // captured two edges earlier, inverted. A key's debounced level flips once the
  // last DC+1 observed samples all disagree with it.
  logic [W-1:0]     raw_hist [$];
  logic [W-1:0]     ks_hist  [$];
  logic [W-1:0]     m_down;
  logic [3*W-1:0]   exp_q    [$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_hist.delete();
      raw_hist.push_back({W{1'b1}});
      raw_hist.push_back({W{1'b1}});
      ks_hist.delete();
      exp_q.delete();
      m_down = '0;
    end else begin
      logic [W-1:0] ks;
      logic [W-1:0] m_pr;
      logic [W-1:0] m_rl;
      raw_hist.push_back(key);
      ks = ~raw_hist[0];
      void'(raw_hist.pop_front());
      ks_hist.push_back(ks);
      if (ks_hist.size() > DC + 1) void'(ks_hist.pop_front());
      m_pr = '0;
      m_rl = '0;
      for (int i = 0; i < W; i++) begin
        bit all_diff;
        all_diff = (ks_hist.size() == DC + 1);
        foreach (ks_hist[j]) if (ks_hist[j][i] == m_down[i]) all_diff = 0;
        if (all_diff) begin
          if (m_down[i]) m_rl[i] = 1'b1;
          else           m_pr[i] = 1'b1;
          m_down[i] = ~m_down[i];
        end
      end
      exp_q.push_back({m_down, m_pr, m_rl});
    end
  end

  // Monitor: compares DUT outputs against the scoreboard each cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outputs", {down, pressed, released}, '0);
    end else if (exp_q.size() > 0) begin
      check("cycle", {down, pressed, released}, exp_q.pop_front());
      if (pressed[1]) int_cnt = int_cnt + 1;
    end
  end

  // Hold key at value k for n cycles (called at posedge + 2).
  task automatic drive(input logic [W-1:0] k, input int n);
    key = k;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("async_reset", {down, pressed, released}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] k;
    n_checks = 0;
    n_errors = 0;
    int_cnt  = 0;
    key      = '1;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {down, pressed, released}, '0);
    #1;
    reset_n = 1'b1;
    drive(4'b1111, 3);

    // Key1 press held for 20 cycles.
    drive(4'b1101, 20);
    check("held_down", {down, pressed, released}, {4'b0010, 4'b0000, 4'b0000});
    // Release glitch then stable release.
    drive(4'b1111, 2);
    drive(4'b1101, 10);
    drive(4'b1111, 12);
    // Bounce: low 2, high 1, low 3, then high.
    drive(4'b1101, 2);
    drive(4'b1111, 1);
    drive(4'b1101, 3);
    drive(4'b1111, 12);
    check("bounce_idle", {down, pressed, released}, '0);
    // Simultaneous key0/key2, then release key0 only.
    drive(4'b1010, 12);
    drive(4'b1011, 12);
    check("partial_release", {down, pressed, released}, {4'b0100, 4'b0000, 4'b0000});
    drive(4'b1111, 12);

    // Reset during PRESS_WAIT.
    drive(4'b0111, 4);
    do_reset();
    #1;
    reset_n = 1'b1;
    drive(4'b0111, 12);
    // Reset during PRESSED, key3 held through release.
    do_reset();
    #1;
    reset_n = 1'b1;
    drive(4'b0111, 12);
    drive(4'b1111, 12);

    // Integration: five bouncy presses of key1 should count exactly five.
    int_cnt = 0;
    for (int p = 0; p < 5; p++) begin
      drive(4'b1101, 1);
      drive(4'b1111, 1);
      drive(4'b1101, 2);
      drive(4'b1111, 1);
      drive(4'b1101, 10);
      drive(4'b1111, 1);
      drive(4'b1101, 1);
      drive(4'b1111, 10);
    end
    n_checks++;
    if (int_cnt != 5) begin
      n_errors++;
      $display("FAIL integration_count: got %0d presses required 5", int_cnt);
    end

    // Random per-key toggling with varying hold lengths.
    k = '1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 5) == 0) k[i] = ~k[i];
      drive(k, $urandom_range(1, 7));
      if (c == 200) begin
        do_reset();
        #1;
        reset_n = 1'b1;
      end
    end
    drive('1, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Upstream conditioning stage for the board push-buttons. Its outputs feed the key-controlled counter logic in top, which consumes one clean pulse per press.
- Synchronises N raw active-low key inputs and filters contact bounce with a per-key counter FSM.
- Outputs a debounced pressed level plus single-cycle press and release pulses per key.
- Replaces the ad-hoc single-flop edge detect on raw key inputs.

Parameters:
- W, 4, number of keys handled (independent channels).
- DEBOUNCE_CYCLES, 50000, cycles key level must be stable to be accepted (1 ms at 50 MHz). Legal range 1 to 2^CNT_W-1.
- CNT_W, 16, width of each per-key stability counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset. Assertion is asynchronous; release is expected to be synchronous to clk at the top level.
- key  input  W  raw board keys, active-low (0 = pressed), asynchronous to clk.
- down  output  W  debounced level, active-high (1 = key held).
- pressed  output  W  one-cycle pulse on accepted press.
- released  output  W  one-cycle pulse on accepted release.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Sync flops are set to 1 (released).
  - All FSMs go to RELEASED and all counters to 0.
  - down, pressed and released are all 0.
- Synchroniser: 2-flop chain per key, then invert: key_s[i] = ~sync2[i]. No logic sits between the two sync flops.
- Per-key FSM, all transitions on posedge clk. Channels are fully independent.
  - RELEASED: down=0. key_s=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: down=0.
    - key_s=0 -> RELEASED. Bounce is rejected and no pulse is generated.
    - Else cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
    - Else cnt<=cnt+1.
  - PRESSED: down=1. key_s=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT: down=1.
    - key_s=1 -> PRESSED, with no pulse.
    - Else cnt==DEBOUNCE_CYCLES-1 -> RELEASED.
    - Else cnt<=cnt+1.
- Outputs are registered:
  - down is 1 exactly in PRESSED and RELEASE_WAIT.
  - pressed[i]=1 for exactly the one cycle after the PRESS_WAIT->PRESSED edge, i.e. the same cycle down rises.
  - released[i]=1 for exactly the one cycle after the RELEASE_WAIT->RELEASED edge, i.e. the same cycle down falls.
- Latency:
  - Number edges from 1 at the first posedge where sync1 captures the new stable raw level.
  - down changes, and the pulse is asserted, after posedge DEBOUNCE_CYCLES+3.
  - With DEBOUNCE_CYCLES=4 this is after edge 7.
- Counter never wraps: the comparison against DEBOUNCE_CYCLES-1 ends counting before overflow. The counter is cleared on every wait-state entry.
- Held key: a single pressed pulse only. There is no auto-repeat.
- Simultaneous events:
  - Keys changing on the same cycle produce pulses on the same cycle, in their own bit positions.
  - pressed and released are never both 1 for the same bit.
- Glitch shorter than DEBOUNCE_CYCLES (as seen at key_s): the state returns to the prior stable state, no output change, no pulse.
- Reset mid-wait: outputs go to 0 immediately (asynchronously).
  - No pulse is emitted on reset exit.
  - A key held through reset release is treated as a new press: it passes through PRESS_WAIT and yields one pressed pulse.
- DEBOUNCE_CYCLES=1: the wait state lasts one cycle; the design must still be correct.

Test Plan:
- DEBOUNCE_CYCLES=4, W=4: reset, then drive key=4'b1101 (key1 pressed) and hold for 20 cycles -> down=4'b0010 and pressed=4'b0010 for one cycle, both after edge 7. pressed stays 0 for the remaining cycles (no repeat).
- Bounce: key1 low for 2 cycles, high for 1, low for 3, then high -> down stays 0 throughout, no pressed pulse, FSM back in RELEASED.
- Release: from the held state, drive key1=1 stable -> released=4'b0010 for one cycle and down=0 after edge 7. A 2-cycle release glitch alone yields neither a pulse nor a down change.
- Simultaneous: key0 and key2 pressed on the same edge -> pressed=4'b0101 in a single cycle. Releasing key0 while key2 is held gives released=4'b0001 and down=4'b0100.
- Reset mid-operation: assert reset_n=0 during PRESS_WAIT and during PRESSED -> down/pressed/released=0 asynchronously. Release reset with key3 held -> exactly one pressed=4'b1000 pulse, DEBOUNCE_CYCLES+3 edges after the first sampling edge.
- Integration: debouncer feeds the 4-bit counter in top; 5 bouncy presses of key1 -> counter increments by exactly 5.
